mem_arbiter: RTL and testbench

Single-port memory arbiter that shares one synchronous single-port RAM between the core's instruction-fetch requester and its load/store requester. Data accesses have priority; a starvation counter guarantees fetch progress under back-to-back loads/stores. Sits between the core's fetch/data ports and the unified RAM; each requester uses a req/gnt/valid handshake.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data requesters, the arbiter and the RAM.
// slave: arbiter view; master: core + RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [31:0]       if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [31:0]       dm_rdata;
    logic              dm_err;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_valid, dm_rdata, dm_err,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_valid, dm_rdata, dm_err,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port sync RAM between fetch and load/store requesters.
// Ports: CLK, RESET (sync, active-high), bus (mem_arbiter_if.slave).
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RET_IF = 2'd1,
        RET_DM = 2'd2
    } state_e;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       ret_we_q, ret_we_d;
    logic       ret_err_q, ret_err_d;

    logic force_if;
    logic gnt_if;
    logic gnt_dm;
    logic dm_mis;
    logic if_vld;
    logic dm_vld;

    // Word-offset and high bits of the fetch address are not decoded.
    logic unused_addr;
    assign unused_addr = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                           bus.dm_addr[31:ADDR_W+2]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            starve_q  <= 4'd0;
            ret_we_q  <= 1'b0;
            ret_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            ret_we_q  <= ret_we_d;
            ret_err_q <= ret_err_d;
        end
    end

    always_comb begin
        state_d   = IDLE;
        starve_d  = 4'd0;
        ret_we_d  = 1'b0;
        ret_err_d = 1'b0;

        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;

        // A starved fetch overrides the normal data-first priority.
        force_if = bus.if_req && (starve_q == SMAX);
        gnt_if   = !RESET && bus.if_req && (force_if || !bus.dm_req);
        gnt_dm   = !RESET && bus.dm_req && !force_if;
        dm_mis   = bus.dm_addr[1:0] != 2'b00;

        if (gnt_dm) begin
            bus.ram_en    = !dm_mis;
            bus.ram_we    = bus.dm_we && !dm_mis;
            bus.ram_addr  = bus.dm_addr[ADDR_W+1:2];
            bus.ram_wdata = bus.dm_wdata;
            state_d       = RET_DM;
            ret_we_d      = bus.dm_we;
            ret_err_d     = dm_mis;
        end else if (gnt_if) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.if_addr[ADDR_W+1:2];
            state_d      = RET_IF;
        end

        if (bus.if_req && !gnt_if) begin
            starve_d = (starve_q == SMAX) ? starve_q : starve_q + 4'd1;
        end

        bus.if_gnt = gnt_if;
        bus.dm_gnt = gnt_dm;

        // A response falling in a reset cycle is dropped.
        if_vld = !RESET && (state_q == RET_IF);
        dm_vld = !RESET && (state_q == RET_DM);

        bus.if_valid = if_vld;
        bus.if_rdata = if_vld ? bus.ram_rdata : 32'd0;
        bus.dm_valid = dm_vld;
        bus.dm_rdata = (dm_vld && !ret_we_q && !ret_err_q)
                     ? bus.ram_rdata : 32'd0;
        bus.dm_err   = dm_vld && ret_err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed grants plus a response
// scoreboard backed by a reference memory image.
module tb_mem_arbiter;

    localparam int AW = 10;

    typedef struct packed {
        logic        iv;
        logic [31:0] ird;
        logic        dv;
        logic [31:0] drd;
        logic        de;
    } resp_t;

    logic CLK = 1'b0;
    logic RESET;

    mem_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    resp_t       sb[$];
    logic [31:0] ram[1024];
    logic [31:0] refm[1024];
    bit          ram_ld = 1'b0;
    bit          ref_ld = 1'b0;

    function automatic logic [31:0] initw(int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Behavioural sync RAM, read-first, 1-cycle read latency.
    always @(posedge CLK) begin
        if (!ram_ld) begin
            for (int i = 0; i < 1024; i++) ram[i] <= initw(i);
            ram_ld <= 1'b1;
        end else if (bus.ram_en) begin
            bus.ram_rdata <= ram[bus.ram_addr];
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    task automatic monitor();
        resp_t       e;
        resp_t       o;
        resp_t       nx;
        logic [43:0] ecmd;
        logic [9:0]  a;
        logic        mis;
        if (!ref_ld) begin
            for (int i = 0; i < 1024; i++) refm[i] = initw(i);
            ref_ld = 1'b1;
            sb.push_back('0);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        if (RESET) e = '0;
        o = {bus.if_valid, bus.if_rdata, bus.dm_valid,
             bus.dm_rdata, bus.dm_err};
        chk("resp", o, e);
        chk("one_gnt", bus.if_gnt & bus.dm_gnt, 0);

        ecmd = '0;
        nx   = '0;
        if (bus.dm_gnt) begin
            a    = bus.dm_addr[11:2];
            mis  = bus.dm_addr[1:0] != 2'b00;
            ecmd = {!mis, bus.dm_we & !mis, a, bus.dm_wdata};
            nx.dv = 1'b1;
            if (mis) nx.de = 1'b1;
            else if (bus.dm_we) refm[a] = bus.dm_wdata;
            else nx.drd = refm[a];
        end else if (bus.if_gnt) begin
            a      = bus.if_addr[11:2];
            ecmd   = {1'b1, 1'b0, a, 32'd0};
            nx.iv  = 1'b1;
            nx.ird = refm[a];
        end
        chk("ram_cmd", {bus.ram_en, bus.ram_we, bus.ram_addr,
                        bus.ram_wdata}, ecmd);
        sb.push_back(nx);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            monitor();
        end
    end

    // Drive one cycle of requests and check who gets the grant.
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd,
                        input logic [1:0] eg, input string tag);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dm_req   = dr;
        bus.dm_we    = dw;
        bus.dm_addr  = da;
        bus.dm_wdata = dd;
        @(negedge CLK);
        chk(tag, {bus.if_gnt, bus.dm_gnt}, eg);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 2'b00, "idle");
    endtask

    initial begin
        RESET = 1'b1;
        step(1, 32'h10, 1, 0, 32'h40, 0, 2'b00, "rst_gnt");
        step(1, 32'h10, 1, 0, 32'h40, 0, 2'b00, "rst_gnt");
        RESET = 1'b0;
        step(1, 32'h10, 1, 0, 32'h40, 0, 2'b01, "first_dm");

        idle();
        step(1, 32'h10, 0, 0, 0, 0, 2'b10, "fetch");
        idle();

        step(0, 0, 1, 1, 32'h20, 32'h1234_5678, 2'b01, "store");
        step(0, 0, 1, 0, 32'h20, 0, 2'b01, "load");
        idle();

        step(0, 0, 1, 1, 32'h22, 32'hFFFF_FFFF, 2'b01, "mis_st");
        idle();
        step(0, 0, 1, 0, 32'h20, 0, 2'b01, "mis_chk");
        step(0, 0, 1, 0, 32'h21, 0, 2'b01, "mis_ld");
        idle();

        step(1, 32'h1000_0010, 0, 0, 0, 0, 2'b10, "wrap_if");
        step(0, 0, 1, 0, 32'hF000_0020, 0, 2'b01, "wrap_dm");
        idle();

        for (int k = 0; k < 15; k++) begin
            step(1, 32'h30, 1, 0, 32'(k * 4), 0,
                 (k % 5 == 4) ? 2'b10 : 2'b01, "contend");
        end
        idle();

        step(0, 0, 1, 1, 32'h50, 32'hCAFE_F00D, 2'b01, "b2b_st");
        step(1, 32'h50, 1, 0, 32'h50, 0, 2'b01, "b2b_ld");
        step(1, 32'h50, 0, 0, 0, 0, 2'b10, "b2b_if");
        idle();

        step(0, 0, 1, 0, 32'h20, 0, 2'b01, "pre_rst");
        RESET = 1'b1;
        step(0, 0, 1, 0, 32'h20, 0, 2'b00, "mid_rst");
        RESET = 1'b0;
        idle();

        for (int k = 0; k < 3; k++)
            step(1, 32'h10, 1, 0, 32'h8, 0, 2'b01, "pre_starve");
        RESET = 1'b1;
        step(1, 32'h10, 1, 0, 32'h8, 0, 2'b00, "rst_starve");
        RESET = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1, 32'h10, 1, 0, 32'h8, 0,
                 (k == 4) ? 2'b10 : 2'b01, "post_starve");
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
